// File: rtl/sdm_codec_if.sv
// PCM/SDM handshake bundle shared by the codec core and whatever drives it.
// master drives the PCM and bitstream inputs; slave is the codec core.
interface sdm_codec_if #(parameter int DATA_W = 16);
  logic              valid_in_dac1, valid_in_dac2;
  logic [DATA_W-1:0] audio_in1, audio_in2;
  logic              valid_in_adc1, valid_in_adc2;
  logic              sdm_in1, sdm_in2;
  logic              valid_out_dac1, valid_out_dac2;
  logic              sdm_out1, sdm_out2;
  logic              valid_out_adc1, valid_out_adc2;
  logic [DATA_W-1:0] audio_out1, audio_out2;

  modport master (
    output valid_in_dac1, valid_in_dac2, audio_in1, audio_in2,
           valid_in_adc1, valid_in_adc2, sdm_in1, sdm_in2,
    input  valid_out_dac1, valid_out_dac2, sdm_out1, sdm_out2,
           valid_out_adc1, valid_out_adc2, audio_out1, audio_out2
  );

  modport slave (
    input  valid_in_dac1, valid_in_dac2, audio_in1, audio_in2,
           valid_in_adc1, valid_in_adc2, sdm_in1, sdm_in2,
    output valid_out_dac1, valid_out_dac2, sdm_out1, sdm_out2,
           valid_out_adc1, valid_out_adc2, audio_out1, audio_out2
  );
endinterface

// File: rtl/sdm_codec_top.sv
// Two-lane sigma-delta codec: first-order error-feedback PCM->1-bit modulator
// and boxcar 1-bit->PCM decimator per lane; lanes share nothing but the clock.
module sdm_codec_lane #(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld_dac,
  input  logic [DATA_W-1:0] i_audio,
  input  logic              i_vld_adc,
  input  logic              i_sdm,
  output logic              o_vld_dac,
  output logic              o_sdm,
  output logic              o_vld_adc,
  output logic [DATA_W-1:0] o_audio
);
  localparam int V_W   = DATA_W + 2;
  localparam int SHIFT = DATA_W - DECIM_LOG2;
  localparam logic signed [V_W-1:0] HALF =
    {{(V_W-DECIM_LOG2){1'b0}}, 1'b1, {(DECIM_LOG2-1){1'b0}}};
  localparam logic signed [V_W-1:0] MAXP = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] MINN = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic [DECIM_LOG2-1:0] CNT_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

  // DAC: the carry out of the phase accumulator is the output bit
  logic [DATA_W-1:0] r_acc;
  logic              r_sdm, r_vld_dac;
  logic [DATA_W-1:0] w_u;
  logic [DATA_W:0]   w_sum;

  assign w_u   = i_audio ^ {1'b1, {(DATA_W-1){1'b0}}};
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sdm     <= 1'b0;
      r_vld_dac <= 1'b0;
    end else begin
      r_vld_dac <= i_vld_dac;
      if (i_vld_dac) begin
        r_acc <= w_sum[DATA_W-1:0];
        r_sdm <= w_sum[DATA_W];
      end
    end
  end

  // ADC: count ones over 2**DECIM_LOG2 valid bits, then scale to full-scale PCM
  logic [DECIM_LOG2:0]          r_ones;
  logic [DECIM_LOG2-1:0]        r_cnt;
  logic                         r_vld_adc;
  logic [DATA_W-1:0]            r_audio;
  logic [DECIM_LOG2:0]          w_ones_tot;
  logic                         w_last;
  logic signed [V_W-1:0]        w_diff, w_v;
  logic [DATA_W-1:0]            w_sat;

  assign w_ones_tot = r_ones + {{DECIM_LOG2{1'b0}}, i_sdm};
  assign w_last     = &r_cnt;
  assign w_diff     = $signed({{(V_W-DECIM_LOG2-1){1'b0}}, w_ones_tot}) - HALF;
  assign w_v        = w_diff <<< SHIFT;

  // Only an all-ones window overflows the positive range
  always_comb begin
    w_sat = w_v[DATA_W-1:0];
    if (w_v > MAXP)      w_sat = MAXP[DATA_W-1:0];
    else if (w_v < MINN) w_sat = MINN[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones    <= '0;
      r_cnt     <= '0;
      r_vld_adc <= 1'b0;
      r_audio   <= '0;
    end else begin
      r_vld_adc <= 1'b0;
      if (i_vld_adc) begin
        if (w_last) begin
          r_audio   <= w_sat;
          r_vld_adc <= 1'b1;
          r_ones    <= '0;
          r_cnt     <= '0;
        end else begin
          r_ones <= w_ones_tot;
          r_cnt  <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign o_vld_dac = r_vld_dac;
  assign o_sdm     = r_sdm;
  assign o_vld_adc = r_vld_adc;
  assign o_audio   = r_audio;
endmodule

module sdm_codec_top #(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  sdm_codec_if.slave  bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             w_vin_dac, w_vin_adc, w_sdm_in;
  logic [NUM_LANES-1:0]             w_vout_dac, w_vout_adc, w_sdm_out;
  logic [NUM_LANES-1:0][DATA_W-1:0] w_audio_in, w_audio_out;

  assign w_vin_dac  = {bus.valid_in_dac2, bus.valid_in_dac1};
  assign w_vin_adc  = {bus.valid_in_adc2, bus.valid_in_adc1};
  assign w_sdm_in   = {bus.sdm_in2, bus.sdm_in1};
  assign w_audio_in = {bus.audio_in2, bus.audio_in1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sdm_codec_lane #(.DATA_W(DATA_W), .DECIM_LOG2(DECIM_LOG2)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_vld_dac (w_vin_dac[g]),
      .i_audio   (w_audio_in[g]),
      .i_vld_adc (w_vin_adc[g]),
      .i_sdm     (w_sdm_in[g]),
      .o_vld_dac (w_vout_dac[g]),
      .o_sdm     (w_sdm_out[g]),
      .o_vld_adc (w_vout_adc[g]),
      .o_audio   (w_audio_out[g])
    );
  end

  assign bus.valid_out_dac1 = w_vout_dac[0];
  assign bus.valid_out_dac2 = w_vout_dac[1];
  assign bus.sdm_out1       = w_sdm_out[0];
  assign bus.sdm_out2       = w_sdm_out[1];
  assign bus.valid_out_adc1 = w_vout_adc[0];
  assign bus.valid_out_adc2 = w_vout_adc[1];
  assign bus.audio_out1     = w_audio_out[0];
  assign bus.audio_out2     = w_audio_out[1];
endmodule

// File: tb/tb_sdm_codec_top.sv
// Bench for sdm_codec_top: randomized DAC/ADC/loopback traffic against a
// closed-form density model (ones in first k bits = floor(k*u/65536)).
module tb_sdm_codec_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdm_codec_if bus ();
  sdm_codec_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic lb_en = 1'b0;
  logic tb_vadc1 = 1'b0, tb_vadc2 = 1'b0, tb_sdm1 = 1'b0, tb_sdm2 = 1'b0;
  assign bus.valid_in_adc1 = lb_en ? bus.valid_out_dac1 : tb_vadc1;
  assign bus.valid_in_adc2 = lb_en ? bus.valid_out_dac2 : tb_vadc2;
  assign bus.sdm_in1       = lb_en ? bus.sdm_out1       : tb_sdm1;
  assign bus.sdm_in2       = lb_en ? bus.sdm_out2       : tb_sdm2;

  int vectors = 0;
  int miscompares = 0;

  // ones among the first k modulator bits for offset input u
  function automatic int dac_ones(input int k, input int u);
    longint p;
    p = longint'(k) * longint'(u);
    return int'(p >>> 16);
  endfunction

  function automatic logic [15:0] pcm_of(input int ones);
    int v;
    v = (ones - 32) * 1024;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic idle_inputs();
    bus.valid_in_dac1 = 1'b0; bus.valid_in_dac2 = 1'b0;
    bus.audio_in1 = '0; bus.audio_in2 = '0;
    tb_vadc1 = 1'b0; tb_vadc2 = 1'b0; tb_sdm1 = 1'b0; tb_sdm2 = 1'b0;
    lb_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in_dac1 = 1'b1; bus.valid_in_dac2 = 1'b1;
    bus.audio_in1 = 16'($urandom); bus.audio_in2 = 16'($urandom);
    tb_vadc1 = 1'b1; tb_vadc2 = 1'b1; tb_sdm1 = 1'b1; tb_sdm2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.valid_out_dac1, bus.valid_out_dac2, bus.sdm_out1, bus.sdm_out2,
           bus.valid_out_adc1, bus.valid_out_adc2, bus.audio_out1, bus.audio_out2} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h%h req=0", i, bus.audio_out1, bus.audio_out2);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.valid_out_dac1, bus.valid_out_dac2, bus.sdm_out1, bus.sdm_out2,
           bus.valid_out_adc1, bus.valid_out_adc2, bus.audio_out1, bus.audio_out2} !== '0) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got nonzero outputs req=0", i);
      end
    end
  endtask

  task automatic test_dac(input logic [15:0] a1, input logic [15:0] a2, input int n, input bit gate);
    int u1, u2, k1, k2, ones1;
    logic e1, e2, v1, v2;
    u1 = int'(a1 ^ 16'h8000);
    u2 = int'(a2 ^ 16'h8000);
    do_reset();
    k1 = 0; k2 = 0; e1 = 1'b0; e2 = 1'b0; ones1 = 0;
    for (int i = 0; i < n; i++) begin
      v1 = gate ? 1'($urandom_range(0, 1)) : 1'b1;
      v2 = gate ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.valid_in_dac1 = v1; bus.audio_in1 = a1;
      bus.valid_in_dac2 = v2; bus.audio_in2 = a2;
      @(negedge clk);
      if (v1) begin
        k1++;
        e1 = 1'(dac_ones(k1, u1) - dac_ones(k1 - 1, u1));
        if (k1 <= 64 && bus.sdm_out1 === 1'b1) ones1++;
      end
      if (v2) begin
        k2++;
        e2 = 1'(dac_ones(k2, u2) - dac_ones(k2 - 1, u2));
      end
      vectors += 4;
      if (bus.valid_out_dac1 !== v1) begin
        miscompares++; $display("FAIL dac_valid1 cyc=%0d got=%b req=%b", i, bus.valid_out_dac1, v1);
      end
      if (bus.valid_out_dac2 !== v2) begin
        miscompares++; $display("FAIL dac_valid2 cyc=%0d got=%b req=%b", i, bus.valid_out_dac2, v2);
      end
      if (bus.sdm_out1 !== e1) begin
        miscompares++; $display("FAIL dac_sdm1 in=%h cyc=%0d got=%b req=%b", a1, i, bus.sdm_out1, e1);
      end
      if (bus.sdm_out2 !== e2) begin
        miscompares++; $display("FAIL dac_sdm2 in=%h cyc=%0d got=%b req=%b", a2, i, bus.sdm_out2, e2);
      end
    end
    vectors++;
    if (k1 < 64 || ones1 !== dac_ones(64, u1)) begin
      miscompares++;
      $display("FAIL dac_density64 in=%h bits=%0d got=%0d req=%0d", a1, k1, ones1, dac_ones(64, u1));
    end
    idle_inputs();
  endtask

  task automatic test_loopback(input logic [15:0] a1, input logic [15:0] a2, input int n, input bit gate);
    int u1, u2, w, last_strobe, nstrobe;
    int nth [0:400];
    bit hv [0:400];
    logic v, es;
    logic [15:0] x1, x2;
    u1 = int'(a1 ^ 16'h8000);
    u2 = int'(a2 ^ 16'h8000);
    do_reset();
    lb_en = 1'b1;
    nth[0] = 0; hv[0] = 1'b0;
    x1 = '0; x2 = '0; last_strobe = 0; nstrobe = 0;
    for (int i = 1; i <= n; i++) begin
      v = gate ? 1'(i % 2) : 1'b1;
      bus.valid_in_dac1 = v; bus.audio_in1 = a1;
      bus.valid_in_dac2 = v; bus.audio_in2 = a2;
      @(negedge clk);
      hv[i] = v;
      nth[i] = nth[i-1] + int'(v);
      es = hv[i-1] && nth[i-1] > 0 && (nth[i-1] % 64) == 0;
      if (es) begin
        w = nth[i-1] / 64;
        x1 = pcm_of(dac_ones(64 * w, u1) - dac_ones(64 * (w - 1), u1));
        x2 = pcm_of(dac_ones(64 * w, u2) - dac_ones(64 * (w - 1), u2));
        nstrobe++;
        vectors++;
        if (last_strobe > 0 && (i - last_strobe) != (gate ? 128 : 64)) begin
          miscompares++;
          $display("FAIL lb_period cyc=%0d got=%0d req=%0d", i, i - last_strobe, gate ? 128 : 64);
        end
        last_strobe = i;
      end
      vectors += 4;
      if (bus.valid_out_adc1 !== es) begin
        miscompares++; $display("FAIL lb_strobe1 cyc=%0d got=%b req=%b", i, bus.valid_out_adc1, es);
      end
      if (bus.valid_out_adc2 !== es) begin
        miscompares++; $display("FAIL lb_strobe2 cyc=%0d got=%b req=%b", i, bus.valid_out_adc2, es);
      end
      if (bus.audio_out1 !== x1) begin
        miscompares++; $display("FAIL lb_audio1 in=%h cyc=%0d got=%h req=%h", a1, i, bus.audio_out1, x1);
      end
      if (bus.audio_out2 !== x2) begin
        miscompares++; $display("FAIL lb_audio2 in=%h cyc=%0d got=%h req=%h", a2, i, bus.audio_out2, x2);
      end
    end
    vectors++;
    if (nstrobe < 2) begin
      miscompares++; $display("FAIL lb_window_count got=%0d req>=2", nstrobe);
    end
    idle_inputs();
  endtask

  task automatic test_adc_random(input int n, input int dens1, input int dens2);
    bit q1[$], q2[$];
    logic v1, v2, b1, b2, s1, s2;
    logic [15:0] x1, x2;
    int sum;
    do_reset();
    x1 = '0; x2 = '0;
    for (int i = 0; i < n; i++) begin
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 99) < dens1); b2 = ($urandom_range(0, 99) < dens2);
      tb_vadc1 = v1; tb_sdm1 = b1; tb_vadc2 = v2; tb_sdm2 = b2;
      @(negedge clk);
      s1 = 1'b0; s2 = 1'b0;
      if (v1) q1.push_back(b1);
      if (v2) q2.push_back(b2);
      if (q1.size() == 64) begin
        sum = 0; foreach (q1[j]) sum += int'(q1[j]);
        x1 = pcm_of(sum); s1 = 1'b1; q1.delete();
      end
      if (q2.size() == 64) begin
        sum = 0; foreach (q2[j]) sum += int'(q2[j]);
        x2 = pcm_of(sum); s2 = 1'b1; q2.delete();
      end
      vectors += 4;
      if (bus.valid_out_adc1 !== s1) begin
        miscompares++; $display("FAIL adc_strobe1 cyc=%0d got=%b req=%b", i, bus.valid_out_adc1, s1);
      end
      if (bus.valid_out_adc2 !== s2) begin
        miscompares++; $display("FAIL adc_strobe2 cyc=%0d got=%b req=%b", i, bus.valid_out_adc2, s2);
      end
      if (bus.audio_out1 !== x1) begin
        miscompares++; $display("FAIL adc_audio1 cyc=%0d got=%h req=%h", i, bus.audio_out1, x1);
      end
      if (bus.audio_out2 !== x2) begin
        miscompares++; $display("FAIL adc_audio2 cyc=%0d got=%h req=%h", i, bus.audio_out2, x2);
      end
    end
    idle_inputs();
  endtask

  task automatic test_midreset();
    do_reset();
    tb_vadc1 = 1'b1; tb_sdm1 = 1'b1; tb_vadc2 = 1'b1; tb_sdm2 = 1'b0;
    repeat (64 + 40) @(negedge clk);
    vectors++;
    if (bus.audio_out1 !== 16'h7FFF) begin
      miscompares++; $display("FAIL midrst_pre got=%h req=7fff", bus.audio_out1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.valid_out_adc1, bus.valid_out_adc2, bus.audio_out1, bus.audio_out2} !== '0) begin
      miscompares++; $display("FAIL midrst_clear got=%h/%h req=0", bus.audio_out1, bus.audio_out2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 66; j++) begin
      @(negedge clk);
      vectors += 3;
      if (bus.valid_out_adc1 !== (j == 64) || bus.valid_out_adc2 !== (j == 64)) begin
        miscompares++; $display("FAIL midrst_strobe bit=%0d got=%b%b req=%b", j,
                                bus.valid_out_adc1, bus.valid_out_adc2, j == 64);
      end
      if (bus.audio_out1 !== (j >= 64 ? 16'h7FFF : 16'h0000)) begin
        miscompares++; $display("FAIL midrst_audio1 bit=%0d got=%h", j, bus.audio_out1);
      end
      if (bus.audio_out2 !== (j >= 64 ? 16'h8000 : 16'h0000)) begin
        miscompares++; $display("FAIL midrst_audio2 bit=%0d got=%h", j, bus.audio_out2);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_dac(16'h0000, 16'h8000, 130, 1'b0);
    test_dac(16'hC000, 16'($urandom), 200, 1'b1);
    test_dac(16'h7FFF, 16'h4000, 100, 1'b0);
    for (int t = 0; t < 3; t++) test_dac(16'($urandom), 16'($urandom), 160, 1'b1);
    test_loopback(16'h0000, 16'hC000, 200, 1'b0);
    test_loopback(16'h8000, 16'h7FFF, 200, 1'b0);
    test_loopback(16'($urandom), 16'($urandom), 270, 1'b1);
    test_adc_random(300, 50, 90);
    test_adc_random(300, 100, 0);
    test_adc_random(300, 25, 75);
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
